// File: rtl/pc_sequencer.sv
// Next-address / stall sequencer for the ProgramCounter: sequential fetch, redirects,
// multi-cycle load-use stalls and halt on jump-to-self, plus a saturating stall counter.
module pc_sequencer #(
    parameter int ADDR_W      = 16,
    parameter int PC_INC      = 1,
    parameter int BR_PENALTY  = 2,
    parameter int HALT_DETECT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              hazard_req,
    input  logic [1:0]        hazard_cycles,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              ext_resume,
    output logic [ADDR_W-1:0] pc_next,
    output logic              pc_stall,
    output logic              flush,
    output logic              halted,
    output logic [15:0]       stall_count
);

    typedef enum logic [1:0] {RUN, STALL, FLUSH, HALT} state_t;

    localparam logic [ADDR_W-1:0] INC       = ADDR_W'(PC_INC);
    localparam logic [2:0]        FLUSH_CNT = 3'(BR_PENALTY - 1);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              halted_q, halted_d;
    logic [15:0]       stall_count_q, stall_count_d;
    logic [ADDR_W-1:0] pc_seq;

    assign pc_seq = pc + INC;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pc_next  = pc_seq;
        pc_stall = 1'b0;
        flush    = 1'b0;

        if (reset) begin
            pc_next  = '0;
            pc_stall = 1'b1;
            flush    = 1'b1;
            state_d  = RUN;
            cnt_d    = 3'd0;
        end else if (state_q == HALT) begin
            if (ext_resume) begin
                state_d = RUN;
                cnt_d   = 3'd0;
            end else begin
                pc_next  = pc;
                pc_stall = 1'b1;
                flush    = 1'b1;
            end
        end else if (redirect_valid) begin
            // A redirect wins in RUN, STALL and FLUSH alike and discards any pending stall/flush.
            pc_next = redirect_target;
            flush   = 1'b1;
            if (HALT_DETECT == 1 && redirect_target == redirect_pc) begin
                state_d = HALT;
                cnt_d   = 3'd0;
            end else if (BR_PENALTY > 1) begin
                state_d = FLUSH;
                cnt_d   = FLUSH_CNT;
            end else begin
                state_d = RUN;
                cnt_d   = 3'd0;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (hazard_req) begin
                        pc_next  = pc;
                        pc_stall = 1'b1;
                        if (hazard_cycles > 2'd1) begin
                            state_d = STALL;
                            cnt_d   = {1'b0, hazard_cycles} - 3'd1;
                        end
                    end
                end
                STALL: begin
                    pc_next  = pc;
                    pc_stall = 1'b1;
                    cnt_d    = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        state_d = RUN;
                        cnt_d   = 3'd0;
                    end
                end
                FLUSH: begin
                    flush = 1'b1;
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        state_d = RUN;
                        cnt_d   = 3'd0;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = 3'd0;
                end
            endcase
        end

        halted_d      = (state_d == HALT);
        stall_count_d = stall_count_q;
        if (pc_stall && stall_count_q != 16'hFFFF) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            cnt_q         <= 3'd0;
            halted_q      <= 1'b0;
            stall_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            halted_q      <= halted_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign halted      = halted_q;
    assign stall_count = stall_count_q;

endmodule
